// File: rtl/div_unit.sv
// Iterative RV64M divide/remainder unit: restoring shift-subtract, one quotient bit per cycle.
// Divide-by-zero and signed overflow resolve in one cycle without iterating.
module div_unit #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic            word_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic            kill_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int unsigned CNT_W = 6;
   localparam int unsigned HALF  = 32;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN-1:0]   dsr_q, dsr_d;
   logic              word_q, word_d;
   logic              is_rem_q, is_rem_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic              op_signed, a_neg, b_neg, div_zero, ovf;
   logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, a_sext32, special_res;
   logic [XLEN:0]     trial;
   logic              fits;
   logic [XLEN-1:0]   rem_nxt, quo_nxt, sel, fixed, assembled;

   // Operand decode for the request presented in IDLE
   always_comb begin
      op_signed = ~op_i[0];
      a_sext32  = {{HALF{rs1_data_i[HALF-1]}}, rs1_data_i[HALF-1:0]};
      if (word_i) begin
         a_ext = op_signed ? a_sext32 : {{HALF{1'b0}}, rs1_data_i[HALF-1:0]};
         b_ext = op_signed ? {{HALF{rs2_data_i[HALF-1]}}, rs2_data_i[HALF-1:0]}
                           : {{HALF{1'b0}}, rs2_data_i[HALF-1:0]};
      end else begin
         a_ext = rs1_data_i;
         b_ext = rs2_data_i;
      end
      a_neg    = op_signed & a_ext[XLEN-1];
      b_neg    = op_signed & b_ext[XLEN-1];
      a_mag    = a_neg ? XLEN'(-a_ext) : a_ext;
      b_mag    = b_neg ? XLEN'(-b_ext) : b_ext;
      div_zero = (b_ext == '0);
      ovf      = op_signed & (word_i
                 ? (rs1_data_i[HALF-1:0] == 32'h8000_0000 && rs2_data_i[HALF-1:0] == 32'hFFFF_FFFF)
                 : (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}} && rs2_data_i == '1));
      if (div_zero)
         special_res = op_i[1] ? (word_i ? a_sext32 : rs1_data_i) : '1;
      else
         special_res = op_i[1] ? '0 : (word_i ? a_sext32 : rs1_data_i);
   end

   // One restoring step plus final sign fix and W sign-extension
   always_comb begin
      trial     = {rem_q, quo_q[XLEN-1]};
      fits      = (trial >= {1'b0, dsr_q});
      rem_nxt   = fits ? XLEN'(trial - {1'b0, dsr_q}) : trial[XLEN-1:0];
      quo_nxt   = {quo_q[XLEN-2:0], fits};
      sel       = is_rem_q ? rem_nxt : quo_nxt;
      fixed     = neg_q ? XLEN'(-sel) : sel;
      assembled = word_q ? {{HALF{fixed[HALF-1]}}, fixed[HALF-1:0]} : fixed;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dsr_d    = dsr_q;
      word_d   = word_q;
      is_rem_d = is_rem_q;
      neg_d    = neg_q;
      result_d = result_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i && !kill_i) begin
               word_d   = word_i;
               is_rem_d = op_i[1];
               neg_d    = op_i[1] ? a_neg : (a_neg ^ b_neg);
               if (div_zero || ovf) begin
                  result_d = special_res;
                  done_d   = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  rem_d   = '0;
                  quo_d   = word_i ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
                  dsr_d   = b_mag;
                  cnt_d   = word_i ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (kill_i) begin
               state_d = S_IDLE;
            end else begin
               rem_d = rem_nxt;
               quo_d = quo_nxt;
               if (cnt_q == '0) begin
                  result_d = assembled;
                  done_d   = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dsr_q    <= '0;
         word_q   <= 1'b0;
         is_rem_q <= 1'b0;
         neg_q    <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dsr_q    <= dsr_d;
         word_q   <= word_d;
         is_rem_q <= is_rem_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule
